mem_access_unit: RTL and testbench

- Initiator-side controller that sits between the MIPS datapath and the word-addressed, strobe-triggered data memory.
- Accepts one byte-addressed load/store request at a time and sequences the memory's `MemRead`/`MemWrite` strobes so that address and data are stable before each rising strobe edge.
- Performs sign/zero extension on loads, and read-modify-write for byte and halfword stores.
- Reports completion with a one-cycle `done` pulse, and reports misaligned or out-of-range requests through `err`.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the datapath request/response signals and the data-memory strobe
// bus of mem_access_unit.
//   req/op/addr/wdata      : load/store request from the datapath
//   busy/done/err/rdata    : status and extended load result
//   Address/WriteData      : word index and write word to memory
//   MemRead/MemWrite       : rising-edge-sampled memory strobes
//   ReadData               : memory read word
//   slave  : the access unit itself
//   master : the surrounding environment (datapath + memory)
interface mem_access_unit_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadData;

   modport slave (
      input  req, op, addr, wdata, ReadData,
      output busy, done, err, rdata, Address, WriteData, MemRead, MemWrite
   );

   modport master (
      output req, op, addr, wdata, ReadData,
      input  busy, done, err, rdata, Address, WriteData, MemRead, MemWrite
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Initiator-side load/store sequencer for a word-addressed, strobe-triggered
// data memory. Handles sign/zero extension on loads and read-modify-write
// for byte/halfword stores. Every output is a register.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mem_access_unit_if.slave (request, status, memory strobes)
//
// state | meaning
// IDLE  | waiting for req
// SETUP | Address (and WriteData for SW) driven, strobes low
// RSTB  | MemRead high for one cycle
// CAPT  | ReadData captured: extend into rdata or merge store lane
// WSET  | merged word on WriteData, strobes low
// WSTB  | MemWrite high for one cycle
// FIN   | done pulse (err set for rejected requests)
module mem_access_unit #(
   parameter int RAM_SIZE = 256
) (
   input  logic             clock,
   input  logic             reset_n,
   mem_access_unit_if.slave bus
);

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_LBU = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   localparam logic [31:0] RAM_WORDS = 32'(RAM_SIZE);

   typedef enum logic [2:0] {
      IDLE, SETUP, RSTB, CAPT, WSET, WSTB, FIN
   } state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;

   logic        bad_req;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   // Request check on the live inputs, used only on the accept edge.
   always_comb begin
      bad_req = 1'b0;
      if ((bus.op == OP_LW || bus.op == OP_SW) && bus.addr[1:0] != 2'b00)
         bad_req = 1'b1;
      if ((bus.op == OP_LH || bus.op == OP_LHU || bus.op == OP_SH) && bus.addr[0])
         bad_req = 1'b1;
      if ({2'b00, bus.addr[31:2]} >= RAM_WORDS)
         bad_req = 1'b1;
   end

   // Lane selection, extension and store merge on the captured word.
   always_comb begin
      rd_byte = bus.ReadData[7:0];
      case (lane_q)
         2'd0: rd_byte = bus.ReadData[7:0];
         2'd1: rd_byte = bus.ReadData[15:8];
         2'd2: rd_byte = bus.ReadData[23:16];
         2'd3: rd_byte = bus.ReadData[31:24];
         default: rd_byte = bus.ReadData[7:0];
      endcase
      rd_half = lane_q[1] ? bus.ReadData[31:16] : bus.ReadData[15:0];

      case (op_q)
         OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
         OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
         OP_LBU:  load_ext = {24'd0, rd_byte};
         OP_LHU:  load_ext = {16'd0, rd_half};
         default: load_ext = bus.ReadData;
      endcase

      merged = bus.ReadData;
      if (op_q == OP_SB) begin
         case (lane_q)
            2'd0: merged[7:0]   = wdata_q[7:0];
            2'd1: merged[15:8]  = wdata_q[7:0];
            2'd2: merged[23:16] = wdata_q[7:0];
            2'd3: merged[31:24] = wdata_q[7:0];
            default: merged = bus.ReadData;
         endcase
      end else if (lane_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         op_q          <= 3'd0;
         lane_q        <= 2'd0;
         wdata_q       <= 16'd0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.rdata     <= 32'd0;
         bus.Address   <= 32'd0;
         bus.WriteData <= 32'd0;
         bus.MemRead   <= 1'b0;
         bus.MemWrite  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               if (bus.req) begin
                  op_q     <= bus.op;
                  lane_q   <= bus.addr[1:0];
                  wdata_q  <= bus.wdata[15:0];
                  bus.busy <= 1'b1;
                  if (bad_req) begin
                     // Rejected: straight to FIN, no memory traffic.
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                     state    <= FIN;
                  end else begin
                     bus.Address <= {2'b00, bus.addr[31:2]};
                     if (bus.op == OP_SW)
                        bus.WriteData <= bus.wdata;
                     state <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (op_q == OP_SW) begin
                  bus.MemWrite <= 1'b1;
                  state        <= WSTB;
               end else begin
                  bus.MemRead <= 1'b1;
                  state       <= RSTB;
               end
            end
            RSTB: begin
               bus.MemRead <= 1'b0;
               state       <= CAPT;
            end
            CAPT: begin
               if (op_q == OP_SB || op_q == OP_SH) begin
                  bus.WriteData <= merged;
                  state         <= WSET;
               end else begin
                  bus.rdata <= load_ext;
                  bus.done  <= 1'b1;
                  state     <= FIN;
               end
            end
            WSET: begin
               bus.MemWrite <= 1'b1;
               state        <= WSTB;
            end
            WSTB: begin
               bus.MemWrite <= 1'b0;
               bus.done     <= 1'b1;
               state        <= FIN;
            end
            FIN: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done     <= 1'b0;
               bus.err      <= 1'b0;
               bus.busy     <= 1'b0;
               bus.MemRead  <= 1'b0;
               bus.MemWrite <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit with a behavioural strobe-triggered
// memory: reads on the MemRead rising edge, writes on the MemWrite rising edge.
module tb_mem_access_unit;

   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                          LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   mem_access_unit_if bus();

   mem_access_unit #(.RAM_SIZE(256)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [31:0] mem [256];
   int rd_rises = 0;
   int wr_rises = 0;

   always @(posedge bus.MemRead) begin
      bus.ReadData = mem[bus.Address[7:0]];
      rd_rises++;
   end

   always @(posedge bus.MemWrite) begin
      mem[bus.Address[7:0]] = bus.WriteData;
      wr_rises++;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_done;
      logic [15:0] exp_rdm;
      logic [15:0] exp_wrm;
      int          chk_idx;
      logic [31:0] chk_val;
   } vec_t;

   vec_t vt [18];

   // One request, observed for 12 cycles after the accept edge.
   task automatic run(input int idx, input vec_t v);
      int          done_c, done_n;
      logic        err_s;
      logic [31:0] rd_s, adr1;
      logic [15:0] rdm, wrm;
      done_c = 0; done_n = 0; err_s = 1'b0; rd_s = 32'd0; adr1 = 32'd0;
      rdm = 16'd0; wrm = 16'd0;
      @(negedge clock);
      bus.req = 1'b1; bus.op = v.op; bus.addr = v.addr; bus.wdata = v.wdata;
      @(posedge clock);
      @(negedge clock);
      bus.req = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clock);
         if (bus.MemRead)  rdm[c] = 1'b1;
         if (bus.MemWrite) wrm[c] = 1'b1;
         if (c == 1) adr1 = bus.Address;
         if (bus.done) begin
            done_n++;
            if (done_c == 0) begin
               done_c = c; err_s = bus.err; rd_s = bus.rdata;
            end
         end
      end
      chk($sformatf("v%0d done_cycle", idx), done_c, v.exp_done);
      chk($sformatf("v%0d done_count", idx), done_n, 1);
      chk($sformatf("v%0d err", idx), {31'd0, err_s}, {31'd0, v.exp_err});
      chk($sformatf("v%0d rdata", idx), rd_s, v.exp_rdata);
      chk($sformatf("v%0d memread_cycles", idx), {16'd0, rdm}, {16'd0, v.exp_rdm});
      chk($sformatf("v%0d memwrite_cycles", idx), {16'd0, wrm}, {16'd0, v.exp_wrm});
      chk($sformatf("v%0d mem[%0d]", idx, v.chk_idx), mem[v.chk_idx], v.chk_val);
      if (!v.exp_err)
         chk($sformatf("v%0d Address", idx), adr1, {2'b00, v.addr[31:2]});
   endtask

   initial begin : main
      int          d1, d2, dn, b4;
      int          rr0, wr0;
      vec_t        v;

      bus.req = 1'b0; bus.op = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
      bus.ReadData = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[1] = 32'h80FF7F01;
      mem[2] = 32'hDEADBEEF;
      mem[3] = 32'h11223344;
      mem[5] = 32'h55667788;

      //       op   addr        wdata         rdata after   err done rdm       wrm       idx  mem value
      vt[0]  = '{LW,  32'h008, 32'h0,        32'hDEADBEEF, 0,  4,  16'h0004, 16'h0000, 2,   32'hDEADBEEF};
      vt[1]  = '{LB,  32'h004, 32'h0,        32'h00000001, 0,  4,  16'h0004, 16'h0000, 1,   32'h80FF7F01};
      vt[2]  = '{LB,  32'h006, 32'h0,        32'hFFFFFFFF, 0,  4,  16'h0004, 16'h0000, 1,   32'h80FF7F01};
      vt[3]  = '{LBU, 32'h007, 32'h0,        32'h00000080, 0,  4,  16'h0004, 16'h0000, 1,   32'h80FF7F01};
      vt[4]  = '{LH,  32'h006, 32'h0,        32'hFFFF80FF, 0,  4,  16'h0004, 16'h0000, 1,   32'h80FF7F01};
      vt[5]  = '{LHU, 32'h006, 32'h0,        32'h000080FF, 0,  4,  16'h0004, 16'h0000, 1,   32'h80FF7F01};
      vt[6]  = '{LB,  32'h005, 32'h0,        32'h0000007F, 0,  4,  16'h0004, 16'h0000, 1,   32'h80FF7F01};
      vt[7]  = '{SB,  32'h00D, 32'hFFFFFFAB, 32'h0000007F, 0,  6,  16'h0004, 16'h0020, 3,   32'h1122AB44};
      vt[8]  = '{SH,  32'h00E, 32'h1234CDEF, 32'h0000007F, 0,  6,  16'h0004, 16'h0020, 3,   32'hCDEFAB44};
      vt[9]  = '{LW,  32'h00C, 32'h0,        32'hCDEFAB44, 0,  4,  16'h0004, 16'h0000, 3,   32'hCDEFAB44};
      vt[10] = '{LW,  32'h00A, 32'h0,        32'hCDEFAB44, 1,  1,  16'h0000, 16'h0000, 2,   32'hDEADBEEF};
      vt[11] = '{SH,  32'h005, 32'hFFFF,     32'hCDEFAB44, 1,  1,  16'h0000, 16'h0000, 1,   32'h80FF7F01};
      vt[12] = '{SW,  32'h400, 32'hFFFFFFFF, 32'hCDEFAB44, 1,  1,  16'h0000, 16'h0000, 255, 32'h00000000};
      vt[13] = '{SW,  32'h3FC, 32'h12345678, 32'hCDEFAB44, 0,  3,  16'h0000, 16'h0004, 255, 32'h12345678};
      vt[14] = '{LW,  32'h3FC, 32'h0,        32'h12345678, 0,  4,  16'h0004, 16'h0000, 255, 32'h12345678};
      vt[15] = '{LBU, 32'h00F, 32'h0,        32'h000000CD, 0,  4,  16'h0004, 16'h0000, 3,   32'hCDEFAB44};
      vt[16] = '{LH,  32'h00C, 32'h0,        32'hFFFFAB44, 0,  4,  16'h0004, 16'h0000, 3,   32'hCDEFAB44};
      vt[17] = '{LBU, 32'h3FD, 32'h0,        32'h00000056, 0,  4,  16'h0004, 16'h0000, 255, 32'h12345678};

      // Reset state
      repeat (3) @(negedge clock);
      chk("reset_outputs",
          {bus.busy, bus.done, bus.err, bus.MemRead, bus.MemWrite, 27'd0},
          32'd0);
      chk("reset_rdata", bus.rdata, 32'd0);
      chk("reset_Address", bus.Address, 32'd0);
      chk("reset_WriteData", bus.WriteData, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 18; i++) run(i, vt[i]);

      // Back-to-back with req held high: SW then LW to word 4.
      rr0 = rd_rises; wr0 = wr_rises; d1 = 0; d2 = 0; dn = 0; b4 = 1;
      @(negedge clock);
      bus.req = 1'b1; bus.op = SW; bus.addr = 32'h10; bus.wdata = 32'hA5A55A5A;
      @(posedge clock);
      @(negedge clock);
      bus.op = LW;
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) @(negedge clock);
         if (c == 4) b4 = bus.busy;
         if (bus.done) begin
            dn++;
            if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
         end
         if (c == 5) bus.req = 1'b0;
      end
      chk("b2b busy_after_fin", b4, 0);
      chk("b2b done_count", dn, 2);
      chk("b2b first_done", d1, 3);
      chk("b2b second_done", d2, 8);
      chk("b2b rdata", bus.rdata, 32'hA5A55A5A);
      chk("b2b mem[4]", mem[4], 32'hA5A55A5A);
      chk("b2b memwrite_pulses", wr_rises - wr0, 1);
      chk("b2b memread_pulses", rd_rises - rr0, 1);

      // Reset during CAPT of SB to word 5.
      wr0 = wr_rises; dn = 0;
      @(negedge clock);
      bus.req = 1'b1; bus.op = SB; bus.addr = 32'h15; bus.wdata = 32'h99;
      @(posedge clock);
      @(negedge clock);
      bus.req = 1'b0;
      @(negedge clock);
      chk("rst_capt memread_in_c2", {31'd0, bus.MemRead}, 32'd1);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_capt outputs_low", {28'd0, bus.MemRead, bus.MemWrite, bus.done, bus.busy}, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (bus.done) dn++;
      end
      chk("rst_capt no_done", dn, 0);
      chk("rst_capt no_write", wr_rises - wr0, 0);
      chk("rst_capt mem[5]", mem[5], 32'h55667788);

      // Reset while MemRead is high: the strobe must drop without a clock.
      @(negedge clock);
      bus.req = 1'b1; bus.op = SH; bus.addr = 32'h16; bus.wdata = 32'h1111;
      @(posedge clock);
      @(negedge clock);
      bus.req = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_rstb memread_drop", {31'd0, bus.MemRead}, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      v = '{LH, 32'h016, 32'h0, 32'h00005566, 0, 4, 16'h0004, 16'h0000, 5, 32'h55667788};
      run(18, v);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
